score_tracker: RTL and testbench



---
 rtl/score_pkg.sv | 16 +
 rtl/score_table.sv | 29 ++
 rtl/score_tracker.sv | 44 ++++
 tb/tb_score_tracker.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/score_pkg.sv
// rtl/score_pkg.sv - shared widths, types and compare helper for the score tracker
package score_pkg;

   localparam int PLAYER_W    = 3;
   localparam int SCORE_W     = 3;
   localparam int NUM_PLAYERS = 2 ** PLAYER_W;

   typedef logic [PLAYER_W-1:0] player_id_t;
   typedef logic [SCORE_W-1:0]  score_t;

   // Strictly greater-than so that ties always keep the incumbent value.
   function automatic logic is_higher(input score_t i_cand, input score_t i_cur);
      return i_cand > i_cur;
   endfunction

endpackage

// File: rtl/score_table.sv
// rtl/score_table.sv - per-player best-score register file with indexed write
module score_table
   import score_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  player_id_t i_id,
   input  logic       i_wr_en,
   input  score_t     i_wr_score,
   output score_t     o_best
);

   score_t r_best [NUM_PLAYERS];

   // Read port: the currently addressed player's best score.
   assign o_best = r_best[i_id];

   // Clear every entry on reset; otherwise overwrite the addressed entry when enabled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_PLAYERS; i++) begin
            r_best[i] <= '0;
         end
      end else if (i_wr_en) begin
         r_best[i_id] <= i_wr_score;
      end
   end

endmodule

// File: rtl/score_tracker.sv
// rtl/score_tracker.sv - tracks per-player best scores and the current leader ID
module score_tracker
   import score_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  player_id_t playerID,
   input  score_t     newScore,
   output player_id_t maxSeg
);

   score_t     w_best;
   logic       w_beats_best;
   logic       w_beats_lead;
   player_id_t r_lead_id;
   score_t     r_lead_score;

   // A player's best only ever rises; the leader changes only on a strict improvement.
   assign w_beats_best = is_higher(newScore, w_best);
   assign w_beats_lead = is_higher(newScore, r_lead_score);

   score_table u_table (
      .clk        (clk),
      .rst        (rst),
      .i_id       (playerID),
      .i_wr_en    (w_beats_best),
      .i_wr_score (newScore),
      .o_best     (w_best)
   );

   // Leader registers; the display output comes straight from the registered ID.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_lead_id    <= '0;
         r_lead_score <= '0;
      end else if (w_beats_lead) begin
         r_lead_id    <= playerID;
         r_lead_score <= newScore;
      end
   end

   assign maxSeg = r_lead_id;

endmodule

// File: tb/tb_score_tracker.sv
// tb/tb_score_tracker.sv - directed self-checking bench for score_tracker
`timescale 1ns/1ps
module tb_score_tracker;
   import score_pkg::*;

   logic       clk;
   logic       rst;
   player_id_t playerID;
   score_t     newScore;
   player_id_t maxSeg;

   int n_vec;
   int n_miss;

   score_tracker u_dut (
      .clk      (clk),
      .rst      (rst),
      .playerID (playerID),
      .newScore (newScore),
      .maxSeg   (maxSeg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input int pid, input int sc);
      playerID = player_id_t'(pid);
      newScore = score_t'(sc);
      @(posedge clk);
      #1;
   endtask

   task automatic chk_lead(input string name, input int exp);
      n_vec++;
      if (maxSeg !== player_id_t'(exp)) begin
         n_miss++;
         $display("FAIL %s: maxSeg=%0d expected %0d", name, maxSeg, exp);
      end
   endtask

   task automatic test_reset;
      rst = 1'b0;
      playerID = '0;
      newScore = '0;
      #2;
      chk_lead("reset_async", 0);
      @(posedge clk); @(posedge clk); #1;
      chk_lead("reset_held", 0);
      rst = 1'b1;
      step(0, 0);
      chk_lead("reset_release", 0);
   endtask

   task automatic test_basic;
      step(0, 3);
      chk_lead("p0_s3", 0);
      step(1, 3);
      chk_lead("p1_tie3", 0);
      step(1, 4);
      chk_lead("p1_s4", 1);
   endtask

   task automatic test_takeover;
      step(2, 4);
      chk_lead("p2_tie4", 1);
      step(2, 6);
      chk_lead("p2_s6", 2);
      step(0, 6);
      chk_lead("p0_tie6", 2);
      n_vec++;
      if (u_dut.u_table.r_best[0] !== score_t'(6)) begin
         n_miss++;
         $display("FAIL best0_tie: best[0]=%0d expected 6", u_dut.u_table.r_best[0]);
      end
   endtask

   task automatic test_no_decrease;
      step(0, 1);
      chk_lead("p0_low", 2);
      n_vec++;
      if (u_dut.u_table.r_best[0] !== score_t'(6)) begin
         n_miss++;
         $display("FAIL best0_nodec: best[0]=%0d expected 6", u_dut.u_table.r_best[0]);
      end
      n_vec++;
      if (u_dut.r_lead_score !== score_t'(6)) begin
         n_miss++;
         $display("FAIL lead_nodec: leadScore=%0d expected 6", u_dut.r_lead_score);
      end
   endtask

   task automatic test_max_values;
      step(2, 7);
      chk_lead("p2_s7", 2);
      n_vec++;
      if (u_dut.r_lead_score !== score_t'(7)) begin
         n_miss++;
         $display("FAIL lead_s7: leadScore=%0d expected 7", u_dut.r_lead_score);
      end
      step(7, 7);
      chk_lead("p7_tie7", 2);
      n_vec++;
      if (u_dut.u_table.r_best[7] !== score_t'(7)) begin
         n_miss++;
         $display("FAIL best7: best[7]=%0d expected 7", u_dut.u_table.r_best[7]);
      end
   endtask

   task automatic test_mid_reset;
      #3;
      rst = 1'b0;
      #1;
      chk_lead("midrst_async", 0);
      n_vec++;
      if (u_dut.u_table.r_best[2] !== score_t'(0)) begin
         n_miss++;
         $display("FAIL best2_rst: best[2]=%0d expected 0", u_dut.u_table.r_best[2]);
      end
      playerID = 3'd7;
      newScore = 3'd7;
      @(posedge clk); #1;
      chk_lead("midrst_held", 0);
      rst = 1'b1;
      step(5, 1);
      chk_lead("p5_s1", 5);
   endtask

   task automatic test_back_to_back;
      for (int i = 0; i < 3; i++) begin
         step(5, 1);
         chk_lead("p5_hold", 5);
      end
      step(3, 1);
      chk_lead("p3_tie1", 5);
      step(7, 7);
      chk_lead("p7_s7", 7);
      step(6, 7);
      chk_lead("p6_tie7", 7);
   endtask

   initial begin
      n_vec  = 0;
      n_miss = 0;
      test_reset();
      test_basic();
      test_takeover();
      test_no_decrease();
      test_max_values();
      test_mid_reset();
      test_back_to_back();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
